// File: rtl/i2c_page_writer.sv
// i2c_page_writer: page-write sequencer that drives an I2C byte engine for 24Cxx EEPROMs.
// Define I2C_PAGEWR_POLL_EN to add post-write ACK polling bounded by MAX_POLLS attempts.

module i2c_page_writer #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned MAX_POLLS  = 255
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         wr_strobe,
  input  logic [7:0]                   wr_data,
  input  logic                         start,
  input  logic [2:0]                   block_sel,
  input  logic [7:0]                   word_addr,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
  output logic                         busy,
  output logic                         done,
  output logic [2:0]                   err_code,
  output logic                         overflow,
  output logic [7:0]                   eng_byte,
  output logic                         eng_do_start,
  output logic                         eng_do_stop,
  output logic                         eng_go,
  input  logic                         eng_done,
  input  logic                         eng_nack
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned SW = LW + 1;

  localparam logic [2:0] ERR_OK           = 3'd0;
  localparam logic [2:0] ERR_EMPTY        = 3'd1;
  localparam logic [2:0] ERR_BOUNDARY     = 3'd2;
  localparam logic [2:0] ERR_NACK_DEVSEL  = 3'd3;
  localparam logic [2:0] ERR_NACK_DATA    = 3'd4;
  localparam logic [2:0] ERR_POLL_TIMEOUT = 3'd5;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LAUNCH,
    S_DEVSEL,
    S_ADDR,
    S_DATA,
    S_POLL,
    S_PSTOP,
    S_STOPERR,
    S_FINISH
  } state_t;

  state_t        r_state, w_state_next;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [LW-1:0] r_level, w_level_next, r_remain;
  logic [SW-1:0] w_span;

  logic [2:0]    r_bsel;
  logic [7:0]    r_addr;
  logic [2:0]    r_err, w_err_next;
  logic          r_overflow;

  logic          r_eng_go, w_go;
  logic [7:0]    r_eng_byte, w_byte;
  logic          r_eng_do_start, w_dstart;
  logic          r_eng_do_stop, w_dstop;

  logic          w_push_ok, w_accept, w_pop, w_flush;
  logic [7:0]    w_devsel, w_head;

`ifdef I2C_PAGEWR_POLL_EN
  localparam logic [7:0] POLL_LAST = 8'(MAX_POLLS);
  logic [7:0]    r_polls;
  logic          r_poll_acked;
  logic          w_poll_nack, w_poll_ack;
`else
  // MAX_POLLS only has meaning when polling is built in.
  logic          w_unused_max_polls;
  assign w_unused_max_polls = (MAX_POLLS == 0);
`endif

  assign w_push_ok    = wr_strobe && (r_state == S_IDLE) && (r_level != LW'(FIFO_DEPTH));
  assign w_level_next = r_level + LW'(w_push_ok);
  assign w_span       = SW'(word_addr[AW-1:0]) + SW'(w_level_next);
  assign w_devsel     = {4'b1010, r_bsel, 1'b0};
  assign w_head       = r_mem[r_rptr];

  assign fifo_level   = r_level;
  assign busy         = (r_state != S_IDLE) && (r_state != S_FINISH);
  assign done         = (r_state == S_FINISH);
  assign err_code     = r_err;
  assign overflow     = r_overflow;
  assign eng_byte     = r_eng_byte;
  assign eng_do_start = r_eng_do_start;
  assign eng_do_stop  = r_eng_do_stop;
  assign eng_go       = r_eng_go;

  // Operands are registered on the same edge that launches eng_go, so the next
  // op is presented exactly one cycle after the previous eng_done.
  always_comb begin
    w_state_next = r_state;
    w_go         = 1'b0;
    w_byte       = r_eng_byte;
    w_dstart     = r_eng_do_start;
    w_dstop      = r_eng_do_stop;
    w_err_next   = r_err;
    w_accept     = 1'b0;
    w_pop        = 1'b0;
    w_flush      = 1'b0;
`ifdef I2C_PAGEWR_POLL_EN
    w_poll_nack  = 1'b0;
    w_poll_ack   = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept   = 1'b1;
          w_err_next = ERR_OK;
          if (w_level_next == '0) begin
            w_err_next   = ERR_EMPTY;
            w_state_next = S_FINISH;
          end else if (w_span > SW'(FIFO_DEPTH)) begin
            w_err_next   = ERR_BOUNDARY;
            w_flush      = 1'b1;
            w_state_next = S_FINISH;
          end else begin
            w_state_next = S_LAUNCH;
          end
        end
      end
      S_LAUNCH: begin
        w_state_next = S_DEVSEL;
        w_go         = 1'b1;
        w_byte       = w_devsel;
        w_dstart     = 1'b1;
        w_dstop      = 1'b0;
      end
      S_DEVSEL, S_ADDR: begin
        if (eng_done) begin
          if (eng_nack) begin
            w_err_next   = ERR_NACK_DEVSEL;
            w_state_next = S_STOPERR;
            w_go         = 1'b1;
            w_byte       = 8'hFF;
            w_dstart     = 1'b0;
            w_dstop      = 1'b1;
            w_flush      = 1'b1;
          end else if (r_state == S_DEVSEL) begin
            w_state_next = S_ADDR;
            w_go         = 1'b1;
            w_byte       = r_addr;
            w_dstart     = 1'b0;
            w_dstop      = 1'b0;
          end else begin
            w_state_next = S_DATA;
            w_go         = 1'b1;
            w_byte       = w_head;
            w_dstart     = 1'b0;
            w_dstop      = (r_remain == LW'(1));
            w_pop        = 1'b1;
          end
        end
      end
      S_DATA: begin
        if (eng_done) begin
          if (eng_nack) begin
            w_err_next   = ERR_NACK_DATA;
            w_state_next = S_STOPERR;
            w_go         = 1'b1;
            w_byte       = 8'hFF;
            w_dstart     = 1'b0;
            w_dstop      = 1'b1;
            w_flush      = 1'b1;
          end else if (r_remain == '0) begin
`ifdef I2C_PAGEWR_POLL_EN
            w_state_next = S_POLL;
            w_go         = 1'b1;
            w_byte       = w_devsel;
            w_dstart     = 1'b1;
            w_dstop      = 1'b0;
`else
            w_state_next = S_FINISH;
`endif
          end else begin
            w_go         = 1'b1;
            w_byte       = w_head;
            w_dstart     = 1'b0;
            w_dstop      = (r_remain == LW'(1));
            w_pop        = 1'b1;
          end
        end
      end
`ifdef I2C_PAGEWR_POLL_EN
      S_POLL: begin
        if (eng_done) begin
          w_poll_nack  = eng_nack;
          w_poll_ack   = !eng_nack;
          w_state_next = S_PSTOP;
          w_go         = 1'b1;
          w_byte       = 8'hFF;
          w_dstart     = 1'b0;
          w_dstop      = 1'b1;
        end
      end
      S_PSTOP: begin
        if (eng_done) begin
          if (r_poll_acked) begin
            w_err_next   = ERR_OK;
            w_state_next = S_FINISH;
          end else if (r_polls == POLL_LAST) begin
            w_err_next   = ERR_POLL_TIMEOUT;
            w_state_next = S_FINISH;
          end else begin
            w_state_next = S_POLL;
            w_go         = 1'b1;
            w_byte       = w_devsel;
            w_dstart     = 1'b1;
            w_dstop      = 1'b0;
          end
        end
      end
`endif
      S_STOPERR: begin
        if (eng_done) w_state_next = S_FINISH;
      end
      S_FINISH: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (w_push_ok) r_mem[r_wptr] <= wr_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_wptr         <= '0;
      r_rptr         <= '0;
      r_level        <= '0;
      r_remain       <= '0;
      r_bsel         <= '0;
      r_addr         <= '0;
      r_err          <= '0;
      r_overflow     <= 1'b0;
      r_eng_go       <= 1'b0;
      r_eng_byte     <= '0;
      r_eng_do_start <= 1'b0;
      r_eng_do_stop  <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_err          <= w_err_next;
      r_eng_go       <= w_go;
      r_eng_byte     <= w_byte;
      r_eng_do_start <= w_dstart;
      r_eng_do_stop  <= w_dstop;
      if (w_push_ok) r_wptr <= r_wptr + AW'(1);
      // A flush may coincide with a same-cycle push; the read pointer skips past it too.
      if (w_flush) begin
        r_rptr  <= w_push_ok ? r_wptr + AW'(1) : r_wptr;
        r_level <= '0;
      end else begin
        if (w_pop) r_rptr <= r_rptr + AW'(1);
        r_level <= w_level_next - LW'(w_pop);
      end
      if (w_accept) begin
        r_bsel     <= block_sel;
        r_addr     <= word_addr;
        r_remain   <= w_level_next;
        r_overflow <= 1'b0;
      end else if (w_pop) begin
        r_remain   <= r_remain - LW'(1);
      end
      if (wr_strobe && !w_push_ok) r_overflow <= 1'b1;
    end
  end

`ifdef I2C_PAGEWR_POLL_EN
  always_ff @(posedge clock) begin
    if (reset || w_accept) begin
      r_polls      <= '0;
      r_poll_acked <= 1'b0;
    end else begin
      if (w_poll_nack) r_polls <= r_polls + 8'd1;
      if (w_poll_ack)  r_poll_acked <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_i2c_page_writer.sv
// Directed bench for i2c_page_writer with a scripted byte-engine responder.
// Expectations follow I2C_PAGEWR_POLL_EN the same way the design does.

module tb_i2c_page_writer;

  logic       clock = 1'b0;
  logic       reset;
  logic       wr_strobe;
  logic [7:0] wr_data;
  logic       start;
  logic [2:0] block_sel;
  logic [7:0] word_addr;
  logic [4:0] fifo_level;
  logic       busy;
  logic       done;
  logic [2:0] err_code;
  logic       overflow;
  logic [7:0] eng_byte;
  logic       eng_do_start;
  logic       eng_do_stop;
  logic       eng_go;
  logic       eng_done;
  logic       eng_nack;

  int checks   = 0;
  int failures = 0;

  logic [9:0] op_q[$];
  logic [9:0] exp_q[$];
  bit         nack_q[$];

  always #5 clock = ~clock;

  i2c_page_writer #(.FIFO_DEPTH(16), .MAX_POLLS(3)) dut (
    .clock        (clock),
    .reset        (reset),
    .wr_strobe    (wr_strobe),
    .wr_data      (wr_data),
    .start        (start),
    .block_sel    (block_sel),
    .word_addr    (word_addr),
    .fifo_level   (fifo_level),
    .busy         (busy),
    .done         (done),
    .err_code     (err_code),
    .overflow     (overflow),
    .eng_byte     (eng_byte),
    .eng_do_start (eng_do_start),
    .eng_do_stop  (eng_do_stop),
    .eng_go       (eng_go),
    .eng_done     (eng_done),
    .eng_nack     (eng_nack)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Engine model: record each op, answer eng_done one cycle later with a scripted NACK.
  initial begin
    logic [9:0] op;
    eng_done = 1'b0;
    eng_nack = 1'b0;
    forever begin
      @(negedge clock);
      eng_done = 1'b0;
      eng_nack = 1'b0;
      if (eng_go === 1'b1) begin
        op = {eng_do_start, eng_do_stop, eng_byte};
        op_q.push_back(op);
        @(negedge clock);
        if (!reset) chk("operand_hold", 32'({eng_do_start, eng_do_stop, eng_byte}), 32'(op));
        eng_done = 1'b1;
        eng_nack = (nack_q.size() > 0) ? nack_q.pop_front() : 1'b0;
      end
    end
  end

  task automatic push(input logic [7:0] b);
    wr_data   = b;
    wr_strobe = 1'b1;
    @(negedge clock);
    wr_strobe = 1'b0;
  endtask

  task automatic go(input logic [2:0] bs, input logic [7:0] wa);
    block_sel = bs;
    word_addr = wa;
    start     = 1'b1;
    @(negedge clock);
    start     = 1'b0;
  endtask

  task automatic wait_done(input int from, input int budget, output int lat);
    lat = from;
    while (done !== 1'b1 && lat < budget) begin
      @(negedge clock);
      lat++;
    end
  endtask

  task automatic chk_ops(input string tag);
    chk({tag, "_opcount"}, 32'(op_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < op_q.size()) chk($sformatf("%s_op%0d", tag, i), 32'(op_q[i]), 32'(exp_q[i]));
    end
  endtask

  initial begin
    int lat;
    int n_start;
    reset     = 1'b1;
    wr_strobe = 1'b0;
    wr_data   = '0;
    start     = 1'b0;
    block_sel = '0;
    word_addr = '0;
    repeat (3) @(negedge clock);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_flags", 32'({busy, done, overflow, eng_go, eng_do_start, eng_do_stop}), 32'd0);
    chk("rst_err", 32'(err_code), 32'd0);
    chk("rst_byte", 32'(eng_byte), 32'd0);
    reset = 1'b0;
    @(negedge clock);

    // Page write, ACK on every op (two NACKed polls when polling is built in)
    push(8'hA1); push(8'hB2); push(8'hC3);
    chk("pw_level_in", 32'(fifo_level), 32'd3);
    op_q.delete();
`ifdef I2C_PAGEWR_POLL_EN
    nack_q = '{0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0};
`else
    nack_q.delete();
`endif
    go(3'b101, 8'h40);
    chk("pw_busy_rise", 32'({busy, eng_go}), 32'b10);
    @(negedge clock);
    chk("pw_first_go", 32'({eng_go, eng_do_start, eng_byte}), 32'h3AA);
    wait_done(2, 200, lat);
`ifdef I2C_PAGEWR_POLL_EN
    chk("pw_latency", 32'(lat), 32'd24);
`else
    chk("pw_latency", 32'(lat), 32'd12);
`endif
    chk("pw_err", 32'(err_code), 32'd0);
    chk("pw_busy_at_done", 32'(busy), 32'd0);
    chk("pw_level_out", 32'(fifo_level), 32'd0);
    exp_q = '{10'h2AA, 10'h040, 10'h0A1, 10'h0B2, 10'h1C3};
`ifdef I2C_PAGEWR_POLL_EN
    repeat (3) begin exp_q.push_back(10'h2AA); exp_q.push_back(10'h1FF); end
`endif
    chk_ops("pw");
    @(negedge clock);

    // Start with empty FIFO
    op_q.delete();
    go(3'b000, 8'h00);
    chk("empty_done", 32'({done, busy}), 32'b10);
    chk("empty_err", 32'(err_code), 32'd1);
    repeat (3) @(negedge clock);
    chk("empty_no_go", 32'(op_q.size()), 32'd0);

    // Page boundary: 14 + 3 > 16
    push(8'h11); push(8'h22); push(8'h33);
    op_q.delete();
    go(3'b000, 8'h0E);
    chk("bnd_done", 32'({done, busy}), 32'b10);
    chk("bnd_err", 32'(err_code), 32'd2);
    chk("bnd_flushed", 32'(fifo_level), 32'd0);
    repeat (3) @(negedge clock);
    chk("bnd_no_go", 32'(op_q.size()), 32'd0);

    // Exact fit (13 + 3 = 16) then NACK on the second data byte
    push(8'h5A); push(8'h6B); push(8'h7C);
    op_q.delete();
    nack_q = '{0, 0, 0, 1};
    go(3'b010, 8'h0D);
    wait_done(1, 200, lat);
    chk("nack_latency", 32'(lat), 32'd12);
    chk("nack_err", 32'(err_code), 32'd4);
    chk("nack_level", 32'(fifo_level), 32'd0);
    exp_q = '{10'h2A4, 10'h00D, 10'h05A, 10'h06B, 10'h1FF};
    chk_ops("nack");
    @(negedge clock);

    // Overflow: 17 pushes, then a full page (poll timeout when polling is built in)
    for (int i = 0; i < 17; i++) push(8'(8'h80 + i));
    chk("ovf_level", 32'(fifo_level), 32'd16);
    chk("ovf_flag", 32'(overflow), 32'd1);
    op_q.delete();
    nack_q.delete();
    for (int i = 0; i < 18; i++) nack_q.push_back(1'b0);
`ifdef I2C_PAGEWR_POLL_EN
    repeat (3) begin nack_q.push_back(1'b1); nack_q.push_back(1'b0); end
`endif
    go(3'b111, 8'h30);
    chk("ovf_cleared", 32'(overflow), 32'd0);
    wait_done(1, 300, lat);
    exp_q = '{10'h2AE, 10'h030};
    for (int i = 0; i < 15; i++) exp_q.push_back(10'(10'h080 + i));
    exp_q.push_back(10'h18F);
`ifdef I2C_PAGEWR_POLL_EN
    repeat (3) begin exp_q.push_back(10'h2AE); exp_q.push_back(10'h1FF); end
    chk("full_latency", 32'(lat), 32'd50);
    chk("full_err", 32'(err_code), 32'd5);
`else
    chk("full_latency", 32'(lat), 32'd38);
    chk("full_err", 32'(err_code), 32'd0);
`endif
    chk_ops("full");
    n_start = 0;
    foreach (op_q[i]) if (op_q[i][9]) n_start++;
`ifdef I2C_PAGEWR_POLL_EN
    chk("poll_starts", 32'(n_start - 1), 32'd3);
`else
    chk("poll_starts", 32'(n_start - 1), 32'd0);
`endif
    @(negedge clock);

    // Reset while the ADDR op is outstanding
    push(8'h01); push(8'h02);
    op_q.delete();
    nack_q.delete();
    go(3'b001, 8'h20);
    repeat (3) @(negedge clock);
    chk("mid_addr_go", 32'({eng_go, eng_byte}), 32'h120);
    reset = 1'b1;
    @(negedge clock);
    chk("mid_rst_level", 32'(fifo_level), 32'd0);
    chk("mid_rst_flags", 32'({busy, done, overflow, eng_go, eng_do_start, eng_do_stop}), 32'd0);
    chk("mid_rst_err_byte", 32'({err_code, eng_byte}), 32'd0);
    reset = 1'b0;
    repeat (4) @(negedge clock);
    chk("mid_rst_no_stop", 32'(op_q.size()), 32'd2);
    go(3'b000, 8'h00);
    chk("mid_rst_fifo_empty", 32'({done, err_code}), 32'h9);
    @(negedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
